// File: rtl/dual_queue_server.sv
// dual_queue_server
// Consumer end of the access controller's request interface. Rising edges on
// en_q / en_p capture din into the priority (Q) or normal (P) FIFO. A serve
// request dispenses one ID, always draining Q before P. Occupancy, full/empty
// status and single-cycle error pulses go to the front-panel display logic.

module dual_queue_server #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 7,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_q,
    input  logic             en_p,
    input  logic [ID_W-1:0]  din,
    input  logic             serve,
    output logic             out_valid,
    output logic [ID_W-1:0]  out_id,
    output logic             out_from_q,
    output logic [CNT_W-1:0] q_count,
    output logic [CNT_W-1:0] p_count,
    output logic             q_full,
    output logic             p_full,
    output logic             q_empty,
    output logic             p_empty,
    output logic             overflow,
    output logic             underflow,
    output logic             conflict
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [AW-1:0]    ONE_PTR  = AW'(1);

    // Storage and pointers for both queues
    logic [ID_W-1:0]  q_mem [DEPTH];
    logic [ID_W-1:0]  p_mem [DEPTH];
    logic [AW-1:0]    q_wr_ptr;
    logic [AW-1:0]    q_rd_ptr;
    logic [AW-1:0]    p_wr_ptr;
    logic [AW-1:0]    p_rd_ptr;

    // Delayed enables for rising-edge detection
    logic             en_q_d;
    logic             en_p_d;

    // Per-cycle decisions
    logic             rise_q;
    logic             rise_p;
    logic             push_q;
    logic             push_p;
    logic             pop_q;
    logic             pop_p;
    logic             accept_q;
    logic             accept_p;
    logic             drop_full;
    logic             conflict_now;
    logic             underflow_now;
    logic             q_at_full;
    logic             p_at_full;
    logic [CNT_W-1:0] q_count_next;
    logic [CNT_W-1:0] p_count_next;

    // Decide pushes, pops and error conditions from the pre-edge state only
    always_comb begin
        rise_q        = en_q & ~en_q_d;
        rise_p        = en_p & ~en_p_d;
        conflict_now  = rise_q & rise_p;
        push_q        = rise_q;
        push_p        = rise_p & ~rise_q;

        q_at_full     = (q_count == FULL_CNT);
        p_at_full     = (p_count == FULL_CNT);

        pop_q         = serve & (q_count != '0);
        pop_p         = serve & (q_count == '0) & (p_count != '0);
        underflow_now = serve & (q_count == '0) & (p_count == '0);

        accept_q      = push_q & (~q_at_full | pop_q);
        accept_p      = push_p & (~p_at_full | pop_p);
        drop_full     = (push_q & ~accept_q) | (push_p & ~accept_p);
    end

    // Next occupancy: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        q_count_next = q_count;
        p_count_next = p_count;
        if (accept_q && !pop_q) begin
            q_count_next = q_count + ONE_CNT;
        end else if (!accept_q && pop_q) begin
            q_count_next = q_count - ONE_CNT;
        end
        if (accept_p && !pop_p) begin
            p_count_next = p_count + ONE_CNT;
        end else if (!accept_p && pop_p) begin
            p_count_next = p_count - ONE_CNT;
        end
    end

    // Enable history; reset loads 1 so a still-high enable never pushes
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q_d <= 1'b1;
            en_p_d <= 1'b1;
        end else begin
            en_q_d <= en_q;
            en_p_d <= en_p;
        end
    end

    // Queue storage writes; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (rst && accept_q) begin
            q_mem[q_wr_ptr] <= din;
        end
        if (rst && accept_p) begin
            p_mem[p_wr_ptr] <= din;
        end
    end

    // Pointer maintenance; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            p_wr_ptr <= '0;
            p_rd_ptr <= '0;
        end else begin
            if (accept_q) begin
                q_wr_ptr <= q_wr_ptr + ONE_PTR;
            end
            if (pop_q) begin
                q_rd_ptr <= q_rd_ptr + ONE_PTR;
            end
            if (accept_p) begin
                p_wr_ptr <= p_wr_ptr + ONE_PTR;
            end
            if (pop_p) begin
                p_rd_ptr <= p_rd_ptr + ONE_PTR;
            end
        end
    end

    // Registered occupancy and status flags reflecting the post-edge state
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_count <= '0;
            p_count <= '0;
            q_full  <= 1'b0;
            p_full  <= 1'b0;
            q_empty <= 1'b1;
            p_empty <= 1'b1;
        end else begin
            q_count <= q_count_next;
            p_count <= p_count_next;
            q_full  <= (q_count_next == FULL_CNT);
            p_full  <= (p_count_next == FULL_CNT);
            q_empty <= (q_count_next == '0);
            p_empty <= (p_count_next == '0);
        end
    end

    // Dispensed ID register; out_id and out_from_q hold between pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_from_q <= 1'b0;
        end else begin
            out_valid <= pop_q | pop_p;
            if (pop_q) begin
                out_id     <= q_mem[q_rd_ptr];
                out_from_q <= 1'b1;
            end else if (pop_p) begin
                out_id     <= p_mem[p_rd_ptr];
                out_from_q <= 1'b0;
            end
        end
    end

    // Single-cycle error pulses, one cycle after the offending event
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            overflow  <= drop_full;
            underflow <= underflow_now;
            conflict  <= conflict_now;
        end
    end

endmodule

// File: tb/tb_dual_queue_server.sv
// tb_dual_queue_server
// Directed scenarios followed by randomized traffic, every cycle compared
// against a queue-based behavioural model of the dual queue server.

module tb_dual_queue_server;

    localparam int DEPTH = 8;
    localparam int ID_W  = 7;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             en_q;
    logic             en_p;
    logic [ID_W-1:0]  din;
    logic             serve;
    logic             out_valid;
    logic [ID_W-1:0]  out_id;
    logic             out_from_q;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] p_count;
    logic             q_full;
    logic             p_full;
    logic             q_empty;
    logic             p_empty;
    logic             overflow;
    logic             underflow;
    logic             conflict;

    dual_queue_server #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_q       (en_q),
        .en_p       (en_p),
        .din        (din),
        .serve      (serve),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_from_q (out_from_q),
        .q_count    (q_count),
        .p_count    (p_count),
        .q_full     (q_full),
        .p_full     (p_full),
        .q_empty    (q_empty),
        .p_empty    (p_empty),
        .overflow   (overflow),
        .underflow  (underflow),
        .conflict   (conflict)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks = 0;
    int failed_checks = 0;

    // Behavioural reference state
    logic [ID_W-1:0] q_model[$];
    logic [ID_W-1:0] p_model[$];
    logic            prev_en_q;
    logic            prev_en_p;
    logic            exp_valid;
    logic [ID_W-1:0] exp_id;
    logic            exp_from_q;
    logic            exp_overflow;
    logic            exp_underflow;
    logic            exp_conflict;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            failed_checks++;
            $display("[TB] FAIL %s at %0t: got %0h, want %0h", tag, $time, actual, expected);
        end
    endtask

    // Advance the reference model by one clock edge
    task automatic model_step(input logic r, input logic eq, input logic ep,
                              input logic [ID_W-1:0] d, input logic s);
        logic rq, rp;
        if (!r) begin
            q_model.delete();
            p_model.delete();
            prev_en_q     = 1'b1;
            prev_en_p     = 1'b1;
            exp_valid     = 1'b0;
            exp_id        = '0;
            exp_from_q    = 1'b0;
            exp_overflow  = 1'b0;
            exp_underflow = 1'b0;
            exp_conflict  = 1'b0;
            return;
        end
        rq = eq && !prev_en_q;
        rp = ep && !prev_en_p;
        exp_conflict  = rq && rp;
        if (rq) rp = 1'b0;
        exp_valid     = 1'b0;
        exp_overflow  = 1'b0;
        exp_underflow = 1'b0;
        // Serve acts on pre-edge contents, so it is resolved before pushes
        if (s) begin
            if (q_model.size() > 0) begin
                exp_id     = q_model.pop_front();
                exp_from_q = 1'b1;
                exp_valid  = 1'b1;
            end else if (p_model.size() > 0) begin
                exp_id     = p_model.pop_front();
                exp_from_q = 1'b0;
                exp_valid  = 1'b1;
            end else begin
                exp_underflow = 1'b1;
            end
        end
        if (rq) begin
            if (q_model.size() < DEPTH) q_model.push_back(d);
            else exp_overflow = 1'b1;
        end
        if (rp) begin
            if (p_model.size() < DEPTH) p_model.push_back(d);
            else exp_overflow = 1'b1;
        end
        prev_en_q = eq;
        prev_en_p = ep;
    endtask

    // Drive one cycle of inputs, update the model, then compare all outputs
    task automatic applyStimulus(input logic r, input logic eq, input logic ep,
                                 input logic [ID_W-1:0] d, input logic s);
        @(negedge clk);
        rst   = r;
        en_q  = eq;
        en_p  = ep;
        din   = d;
        serve = s;
        @(posedge clk);
        model_step(r, eq, ep, d, s);
        #1;
        checkOutput("out_valid",  32'(out_valid),  32'(exp_valid));
        checkOutput("out_id",     32'(out_id),     32'(exp_id));
        checkOutput("out_from_q", 32'(out_from_q), 32'(exp_from_q));
        checkOutput("q_count",    32'(q_count),    32'(q_model.size()));
        checkOutput("p_count",    32'(p_count),    32'(p_model.size()));
        checkOutput("q_full",     32'(q_full),     32'(q_model.size() == DEPTH));
        checkOutput("p_full",     32'(p_full),     32'(p_model.size() == DEPTH));
        checkOutput("q_empty",    32'(q_empty),    32'(q_model.size() == 0));
        checkOutput("p_empty",    32'(p_empty),    32'(p_model.size() == 0));
        checkOutput("overflow",   32'(overflow),   32'(exp_overflow));
        checkOutput("underflow",  32'(underflow),  32'(exp_underflow));
        checkOutput("conflict",   32'(conflict),   32'(exp_conflict));
    endtask

    logic            cur_q;
    logic            cur_p;
    logic            cur_s;
    logic            cur_r;
    logic [ID_W-1:0] cur_d;

    initial begin
        rst   = 1'b0;
        en_q  = 1'b1;
        en_p  = 1'b0;
        din   = '0;
        serve = 1'b0;

        // 1: reset with en_q held high, then keep it high: no push
        applyStimulus(1'b0, 1'b1, 1'b0, 7'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 7'h00, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 7'h00, 1'b0);
        checkOutput("held_en_no_push", 32'(q_count), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b0);

        // 2: one ID into each queue, Q served first
        applyStimulus(1'b1, 1'b1, 1'b0, 7'h15, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 7'h2A, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 7'h00, 1'b1);
        checkOutput("first_serve_id", 32'(out_id), 32'h15);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("second_serve_id", 32'(out_id), 32'h2A);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b0);

        // 3: nine pushes into P, the ninth overflows; drain in order
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 7'(8'h40 + i), 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("p_drain_last", 32'(out_id), 32'h47);

        // 4: serve with both queues empty
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b0);

        // 5: both enables rise together
        applyStimulus(1'b1, 1'b1, 1'b1, 7'h01, 1'b0);
        checkOutput("conflict_q_count", 32'(q_count), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);

        // 6: full Q, push and serve in the same cycle
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 7'(8'h10 + i), 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 7'h7F, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);
        checkOutput("full_pushpop_last", 32'(out_id), 32'h7F);

        // 7: fill both queues, reset mid-stream, then serve underflows
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 7'(i), 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b1, 7'(8'h20 + i), 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 7'h33, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b1);

        // Randomized traffic alternating fill-heavy and drain-heavy phases
        cur_q = 1'b0;
        cur_p = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0) cur_q = ~cur_q;
            if ($urandom_range(0, 2) == 0) cur_p = ~cur_p;
            if (((i / 150) % 2) == 0) cur_s = ($urandom_range(0, 9) < 2);
            else                      cur_s = ($urandom_range(0, 9) < 8);
            cur_r = ($urandom_range(0, 399) != 0);
            cur_d = 7'($urandom);
            applyStimulus(cur_r, cur_q, cur_p, cur_d, cur_s);
        end

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule
